// File: rtl/harris_response.sv
// ---------------------------------------------------------------------------
// harris_response
//
// Five-stage, valid-tagged Harris corner-response pipeline. It takes one 4x4
// pair of signed gradient tiles per cycle and produces
//   R = det(M) - k * trace(M)^2, with k = 2^-K_SHIFT,
// where M = [[Sxx, Sxy], [Sxy, Syy]] is the structure tensor summed over the
// 16 tile elements. All arithmetic is 64-bit two's complement.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every valid bit, R, count
//   win_valid  Gx/Gy carry a window this cycle
//   Gx, Gy     4x4 signed 16-bit gradients, element [row][col]
//   R          signed 64-bit response; holds its value between results
//   r_valid    R / corner / count describe a fresh result this cycle
//   corner     R > THRESH (signed), 0 whenever r_valid is 0
//   count      results emitted since reset, including the current one
//
// Handshake: valid-only, no ready. A window is consumed on every rising edge
// where win_valid=1 and reset=0; the result appears with r_valid=1 after the
// fifth register. Each stage's valid bit travels with its data, and the data
// registers of a stage load only when the valid bit entering it is 1.
// ---------------------------------------------------------------------------
module harris_response #(
    parameter int                 K_SHIFT = 4,
    parameter logic signed [63:0] THRESH  = 64'sd65536
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     win_valid,
    input  logic [0:3][0:3][15:0]    Gx,
    input  logic [0:3][0:3][15:0]    Gy,
    output logic signed [63:0]       R,
    output logic                     r_valid,
    output logic                     corner,
    output logic [63:0]              count
);

    // ---------------- stage 1: per-element products ----------------
    logic signed [63:0] gx_e  [16];
    logic signed [63:0] gy_e  [16];
    logic signed [63:0] xx_d  [16];
    logic signed [63:0] yy_d  [16];
    logic signed [63:0] xy_d  [16];
    logic signed [63:0] xx_q  [16];
    logic signed [63:0] yy_q  [16];
    logic signed [63:0] xy_q  [16];
    logic               v1_q;

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int I = r * 4 + c;
            assign gx_e[I] = {{48{Gx[r][c][15]}}, Gx[r][c]};
            assign gy_e[I] = {{48{Gy[r][c][15]}}, Gy[r][c]};
            assign xx_d[I] = gx_e[I] * gx_e[I];
            assign yy_d[I] = gy_e[I] * gy_e[I];
            assign xy_d[I] = gx_e[I] * gy_e[I];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= win_valid;
        end
        if (win_valid) begin
            for (int i = 0; i < 16; i++) begin
                xx_q[i] <= xx_d[i];
                yy_q[i] <= yy_d[i];
                xy_q[i] <= xy_d[i];
            end
        end
    end

    // ---------------- stage 2: row partial sums ----------------
    logic signed [63:0] rxx_d [4];
    logic signed [63:0] ryy_d [4];
    logic signed [63:0] rxy_d [4];
    logic signed [63:0] rxx_q [4];
    logic signed [63:0] ryy_q [4];
    logic signed [63:0] rxy_q [4];
    logic               v2_q;

    for (genvar r = 0; r < 4; r++) begin : g_rsum
        assign rxx_d[r] = xx_q[4*r] + xx_q[4*r+1] + xx_q[4*r+2] + xx_q[4*r+3];
        assign ryy_d[r] = yy_q[4*r] + yy_q[4*r+1] + yy_q[4*r+2] + yy_q[4*r+3];
        assign rxy_d[r] = xy_q[4*r] + xy_q[4*r+1] + xy_q[4*r+2] + xy_q[4*r+3];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2_q <= 1'b0;
        end else begin
            v2_q <= v1_q;
        end
        if (v1_q) begin
            for (int r = 0; r < 4; r++) begin
                rxx_q[r] <= rxx_d[r];
                ryy_q[r] <= ryy_d[r];
                rxy_q[r] <= rxy_d[r];
            end
        end
    end

    // ---------------- stage 3: tensor sums ----------------
    logic signed [63:0] sxx_d, syy_d, sxy_d;
    logic signed [63:0] sxx_q, syy_q, sxy_q;
    logic               v3_q;

    assign sxx_d = rxx_q[0] + rxx_q[1] + rxx_q[2] + rxx_q[3];
    assign syy_d = ryy_q[0] + ryy_q[1] + ryy_q[2] + ryy_q[3];
    assign sxy_d = rxy_q[0] + rxy_q[1] + rxy_q[2] + rxy_q[3];

    always_ff @(posedge clk) begin
        if (reset) begin
            v3_q <= 1'b0;
        end else begin
            v3_q <= v2_q;
        end
        if (v2_q) begin
            sxx_q <= sxx_d;
            syy_q <= syy_d;
            sxy_q <= sxy_d;
        end
    end

    // ---------------- stage 4: determinant / trace products ----------------
    logic signed [63:0] tr_sum;
    logic signed [63:0] p_d, q_d, t_d;
    logic signed [63:0] p_q, q_q, t_q;
    logic               v4_q;

    assign tr_sum = sxx_q + syy_q;
    assign p_d    = sxx_q * syy_q;
    assign q_d    = sxy_q * sxy_q;
    assign t_d    = tr_sum * tr_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            v4_q <= 1'b0;
        end else begin
            v4_q <= v3_q;
        end
        if (v3_q) begin
            p_q <= p_d;
            q_q <= q_d;
            t_q <= t_d;
        end
    end

    // ---------------- stage 5: response, flag, count ----------------
    logic signed [63:0] r_d;
    logic               corner_d;
    logic signed [63:0] r_q;
    logic               r_valid_q;
    logic               corner_q;
    logic [63:0]        count_q;

    // k * trace^2 with k = 2^-K_SHIFT is an arithmetic right shift.
    assign r_d      = (p_q - q_q) - (t_q >>> K_SHIFT);
    assign corner_d = (r_d > THRESH);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q       <= '0;
            r_valid_q <= 1'b0;
            corner_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            r_valid_q <= v4_q;
            corner_q  <= v4_q & corner_d;
            if (v4_q) begin
                r_q     <= r_d;
                count_q <= count_q + 64'd1;
            end
        end
    end

    assign R       = r_q;
    assign r_valid = r_valid_q;
    assign corner  = corner_q;
    assign count   = count_q;

endmodule

// File: tb/tb_harris_response.sv
// ---------------------------------------------------------------------------
// tb_harris_response
//
// Drives windows right after a rising edge; the DUT captures them on the
// next edge and the result must appear after the fifth register, i.e. four
// edges after capture. The reference model computes R straight from the
// Harris formula on each captured tile and queues it with the edge number at
// which it must emerge. Outputs are compared on every falling edge.
// ---------------------------------------------------------------------------
module tb_harris_response;

    localparam int                 K_SHIFT = 4;
    localparam logic signed [63:0] THRESH  = 64'sd65536;

    typedef logic [0:3][0:3][15:0] tile_t;

    typedef struct {
        longint r;
        int     due;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        win_valid;
    tile_t       gx, gy;
    logic signed [63:0] r_o;
    logic        r_valid_o;
    logic        corner_o;
    logic [63:0] count_o;

    always #5 clk = ~clk;

    harris_response #(.K_SHIFT(K_SHIFT), .THRESH(THRESH)) dut (
        .clk       (clk),
        .reset     (reset),
        .win_valid (win_valid),
        .Gx        (gx),
        .Gy        (gy),
        .R         (r_o),
        .r_valid   (r_valid_o),
        .corner    (corner_o),
        .count     (count_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint model_r(input tile_t x, input tile_t y);
        longint sxx, syy, sxy, a, b, tr;
        shortint sa, sb;
        sxx = 0; syy = 0; sxy = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                sa = x[i][j];
                sb = y[i][j];
                a = sa;
                b = sb;
                sxx += a * a;
                syy += b * b;
                sxy += a * b;
            end
        end
        tr = sxx + syy;
        return (sxx * syy - sxy * sxy) - ((tr * tr) >>> K_SHIFT);
    endfunction

    exp_t        exp_q[$];
    int          cyc = 0;
    bit          started = 1'b0;
    bit          exp_valid = 1'b0;
    bit          exp_corner = 1'b0;
    longint      exp_r = 0;
    logic [63:0] exp_cnt = '0;

    // Runs on the edge, before the driver changes inputs (#1 later).
    always @(posedge clk) begin
        exp_t e;
        cyc++;
        if (reset) begin
            exp_q.delete();
            exp_valid  = 1'b0;
            exp_corner = 1'b0;
            exp_r      = 0;
            exp_cnt    = '0;
            started    = 1'b1;
        end else begin
            if (win_valid) begin
                e.r   = model_r(gx, gy);
                e.due = cyc + 4;
                exp_q.push_back(e);
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                e          = exp_q.pop_front();
                exp_valid  = 1'b1;
                exp_r      = e.r;
                exp_corner = (e.r > longint'(THRESH));
                exp_cnt    = exp_cnt + 64'd1;
            end else begin
                exp_valid  = 1'b0;
                exp_corner = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("r_valid", {63'd0, r_valid_o}, {63'd0, exp_valid});
            chk("corner",  {63'd0, corner_o},  {63'd0, exp_corner});
            chk("count",   count_o, exp_cnt);
            chk("R",       r_o, exp_r);
        end
    end

    // ---------------- driver tasks ----------------
    function automatic tile_t fill(input int v);
        tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[i][j] = 16'(v);
        return t;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        int v;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                v = int'($urandom_range(2040)) - 1020;
                t[i][j] = 16'(v);
            end
        return t;
    endfunction

    function automatic tile_t garbage_tile();
        tile_t t;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                t[i][j] = 16'($urandom);
        return t;
    endfunction

    task automatic send(input bit v, input tile_t tx, input tile_t ty);
        win_valid = v;
        gx = tx;
        gy = ty;
        @(posedge clk);
        #1;
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) send(1'b0, garbage_tile(), garbage_tile());
    endtask

    task automatic pulse_reset(input int n);
        reset = 1'b1;
        win_valid = 1'b1;          // window alongside reset must be dropped
        gx = rand_tile();
        gy = rand_tile();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        win_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    tile_t t_rows_x, t_rows_y;

    initial begin
        reset = 1'b1;
        win_valid = 1'b0;
        gx = '0;
        gy = '0;

        // Hand-computed values pin the model.
        t_rows_x = '0;
        t_rows_y = '0;
        for (int j = 0; j < 4; j++) begin
            t_rows_x[0][j] = 16'd100;
            t_rows_x[1][j] = 16'd100;
            t_rows_y[2][j] = 16'd100;
            t_rows_y[3][j] = 16'd100;
        end
        chk("model_zero",  model_r(fill(0), fill(0)), 64'd0);
        chk("model_ones",  model_r(fill(1), fill(0)), -64'sd16);
        chk("model_rows",  model_r(t_rows_x, t_rows_y), 64'sd4800000000);
        chk("model_max",   model_r(fill(1020), fill(-1020)), -64'sd69275658240000);

        pulse_reset(2);
        bubbles(2);

        // Directed windows, isolated.
        send(1'b1, fill(0), fill(0));         bubbles(6);
        send(1'b1, fill(1), fill(0));         bubbles(6);
        send(1'b1, t_rows_x, t_rows_y);       bubbles(6);
        send(1'b1, fill(1020), fill(-1020));  bubbles(6);

        // 10 back-to-back, 3 bubbles, 2 more.
        for (int i = 0; i < 10; i++) send(1'b1, rand_tile(), rand_tile());
        bubbles(3);
        for (int i = 0; i < 2; i++) send(1'b1, rand_tile(), rand_tile());
        bubbles(8);

        // Reset with 3 windows in flight; next window must emit count=1.
        for (int i = 0; i < 3; i++) send(1'b1, rand_tile(), rand_tile());
        pulse_reset(1);
        send(1'b1, t_rows_x, t_rows_y);
        bubbles(8);

        // Random valid/bubble mix.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) != 0) send(1'b1, rand_tile(), rand_tile());
            else                        send(1'b0, garbage_tile(), garbage_tile());
        end
        bubbles(8);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still expected", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
